// File: rtl/rv32_lsu.sv
// Load/store unit: turns decoder memory controls into a req/gnt/rvalid bus
// transaction, steering store lanes and extending load data while stalling the core.
module rv32_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        MemRW,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        mem_err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WAIT_R = 2'b10, DONE = 2'b11} state_t;

    localparam logic [31:0] TO_LIM = 32'(TIMEOUT);

    state_t      state_r, next_s;
    logic        we_r, uns_r, err_r;
    logic [1:0]  size_r, off_r;
    logic [31:0] cnt_r, rdata_r;
    logic        bus_req_r, bus_we_r;
    logic [31:0] bus_addr_r, bus_wdata_r;
    logic [3:0]  bus_be_r;
    logic        to_err_s, timeout_s, stall_s, done_s, mem_err_s;

    function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_ext(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   r = uns ? {24'd0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            2'b01:   r = uns ? {16'd0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    // Timeout fires in the TIMEOUT-th busy cycle; a zero limit disables it.
    assign timeout_s = (TO_LIM != 32'd0) && ((cnt_r + 32'd1) == TO_LIM);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= next_s;
    end

    // Next-state logic; a bus response in the limit cycle wins over the timeout
    always_comb begin
        next_s   = state_r;
        to_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_valid) next_s = is_bad(MemSize, addr[1:0]) ? DONE : REQ;
                else           next_s = IDLE;
            end
            REQ: begin
                if (bus_gnt)        next_s = we_r ? DONE : WAIT_R;
                else if (timeout_s) begin next_s = DONE; to_err_s = 1'b1; end
                else                next_s = REQ;
            end
            WAIT_R: begin
                if (bus_rvalid)     next_s = DONE;
                else if (timeout_s) begin next_s = DONE; to_err_s = 1'b1; end
                else                next_s = WAIT_R;
            end
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Core-facing outputs decoded from state
    always_comb begin
        stall_s   = 1'b0;
        done_s    = 1'b0;
        mem_err_s = 1'b0;
        stall_s   = mem_valid && (state_r != DONE);
        done_s    = (state_r == DONE);
        mem_err_s = (state_r == DONE) && err_r;
    end

    // Access latches, timeout counter, load result and registered bus signals
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r        <= 1'b0;
            uns_r       <= 1'b0;
            err_r       <= 1'b0;
            size_r      <= 2'b00;
            off_r       <= 2'b00;
            cnt_r       <= 32'd0;
            rdata_r     <= 32'd0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_be_r    <= 4'b0000;
            bus_wdata_r <= 32'd0;
        end else begin
            bus_req_r <= (next_s == REQ);
            rdata_r   <= (state_r == WAIT_R && bus_rvalid) ?
                         load_ext(size_r, uns_r, off_r, bus_rdata) : 32'd0;
            cnt_r     <= (state_r == REQ || state_r == WAIT_R) ? cnt_r + 32'd1 : 32'd0;
            if (state_r == IDLE && mem_valid) begin
                we_r   <= MemRW;
                uns_r  <= MemUnsigned;
                size_r <= MemSize;
                off_r  <= addr[1:0];
                err_r  <= is_bad(MemSize, addr[1:0]);
            end else if (state_r == REQ || state_r == WAIT_R) begin
                err_r  <= to_err_s;
            end
            if (state_r == IDLE && next_s == REQ) begin
                bus_we_r    <= MemRW;
                bus_addr_r  <= {addr[31:2], 2'b00};
                bus_be_r    <= lane_be(MemSize, addr[1:0]);
                bus_wdata_r <= MemRW ? lane_wdata(MemSize, wdata) : 32'd0;
            end else if (next_s != REQ) begin
                bus_we_r    <= 1'b0;
                bus_addr_r  <= 32'd0;
                bus_be_r    <= 4'b0000;
                bus_wdata_r <= 32'd0;
            end
        end
    end

    assign stall     = stall_s;
    assign done      = done_s;
    assign mem_err   = mem_err_s;
    assign rdata     = rdata_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_be    = bus_be_r;
    assign bus_wdata = bus_wdata_r;
endmodule

// File: tb/tb_rv32_lsu.sv
// Randomized scoreboard bench for rv32_lsu: a bus responder and a done monitor
// check the DUT against a byte-lane reference model of loads and stores.
module tb_rv32_lsu;
    logic        clk = 1'b0;
    logic        rst_n, mem_valid, MemRW, MemUnsigned;
    logic [1:0]  MemSize;
    logic [31:0] addr, wdata;
    logic        stall, done, mem_err;
    logic [31:0] rdata;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    always #5 clk = ~clk;

    rv32_lsu #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .MemRW(MemRW),
        .MemSize(MemSize), .MemUnsigned(MemUnsigned), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .mem_err(mem_err), .rdata(rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    typedef struct packed { logic err; logic [31:0] rdata; } resp_t;
    typedef struct packed { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } busx_t;

    resp_t resp_q[$];
    busx_t bus_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cfg_g = 0, cfg_r = 0;
    logic cfg_no_gnt = 1'b0, cfg_no_rv = 1'b0;
    logic [31:0] cfg_word = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input int size);
        return (size == 0) ? 1 : (size == 1) ? 2 : 4;
    endfunction

    function automatic bit ref_bad(input int size, input logic [31:0] a);
        return (size == 3) || (size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0);
    endfunction

    function automatic logic [3:0] ref_be(input int size, input logic [31:0] a);
        logic [3:0] be;
        int o = int'(a % 4);
        for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + nbytes(size));
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input int size, input logic [31:0] wd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % nbytes(size)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input int size, input bit uns,
                                             input logic [31:0] a, input logic [31:0] word);
        logic [31:0] v, mask;
        int n = nbytes(size);
        v = word >> (8 * int'(a % 4));
        if (n == 4) return v;
        mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = v & mask;
        if (!uns && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Monitor: every done pulse retires the oldest expected response
    always @(negedge clk) begin : mon
        resp_t r;
        if (rst_n) begin
            if (mem_err && !done) check("mem_err_without_done", 32'(mem_err), 32'd0);
            if (done) begin
                if (resp_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
                else begin
                    r = resp_q.pop_front();
                    check("mem_err", 32'(mem_err), 32'(r.err));
                    check("rdata", rdata, r.rdata);
                end
            end
        end
    end

    // Bus responder: checks each new request, then grants and returns read data
    initial begin : responder
        busx_t e;
        logic we;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (bus_req && rst_n) begin
                if (bus_q.size() == 0) check("unexpected_bus_req", 32'(bus_req), 32'd0);
                else begin
                    e = bus_q.pop_front();
                    check("bus_we", 32'(bus_we), 32'(e.we));
                    check("bus_addr", bus_addr, e.addr);
                    check("bus_be", 32'(bus_be), 32'(e.be));
                    if (e.we) check("bus_wdata", bus_wdata, e.wdata);
                end
                we = bus_we;
                if (cfg_no_gnt) begin
                    while (bus_req) @(negedge clk);
                end else begin
                    repeat (cfg_g) @(negedge clk);
                    bus_gnt = 1'b1;
                    @(negedge clk);
                    bus_gnt = 1'b0;
                    if (!we && !cfg_no_rv) begin
                        repeat (cfg_r) @(negedge clk);
                        bus_rvalid = 1'b1; bus_rdata = cfg_word;
                        @(negedge clk);
                        bus_rvalid = 1'b0; bus_rdata = $urandom;
                    end
                end
            end
        end
    end

    task automatic do_op(input bit rw, input int size, input bit uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word, input int g,
                         input int r, input bit no_gnt, input bit no_rv, input bit drop);
        bit bad, to, stall_ok;
        int exp_lat, exp_req, cyc, reqc;
        resp_t er;
        busx_t eb;
        bad = ref_bad(size, a);
        to  = !bad && (no_gnt || (!rw && no_rv));
        er.err   = bad || to;
        er.rdata = (bad || to || rw) ? 32'd0 : ref_load(size, uns, a, word);
        exp_req  = bad ? 0 : no_gnt ? 8 : g + 1;
        exp_lat  = bad ? 2 : to ? 10 : rw ? g + 3 : g + r + 4;
        cfg_g = g; cfg_r = r; cfg_no_gnt = no_gnt; cfg_no_rv = no_rv; cfg_word = word;
        resp_q.push_back(er);
        if (!bad) begin
            eb.we = rw; eb.addr = a - (a % 4); eb.be = ref_be(size, a);
            eb.wdata = ref_wdata(size, wd);
            bus_q.push_back(eb);
        end
        @(negedge clk);
        mem_valid = 1'b1; MemRW = rw; MemSize = size[1:0]; MemUnsigned = uns;
        addr = a; wdata = wd;
        cyc = 1; reqc = 0; stall_ok = 1'b1;
        #1;
        if (stall !== 1'b1) stall_ok = 1'b0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus_req) reqc++;
            if (done) break;
            if (stall !== mem_valid) stall_ok = 1'b0;
            if (drop && cyc == 2) begin
                mem_valid = 1'b0; MemRW = $urandom; MemSize = $urandom;
                addr = $urandom; wdata = $urandom;
            end
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        check("req_cycles", 32'(reqc), 32'(exp_req));
        check("stall_until_done", 32'(stall_ok), 32'd1);
        check("stall_at_done", 32'(stall), 32'd0);
        mem_valid = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        busx_t eb;
        int n_done;
        rst_n = 1'b0; mem_valid = 1'b0; MemRW = 1'b0; MemSize = 2'b00; MemUnsigned = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        do_op(1'b1, 2, 1'b0, 32'h100, 32'hDEADBEEF, 32'd0, 1, 0, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 0, 1'b0, 32'h103, 32'h000000A5, 32'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 0, 1'b0, 32'h201, 32'd0, 32'h12348056, 0, 0, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 0, 1'b1, 32'h201, 32'd0, 32'h12348056, 2, 1, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 1, 1'b0, 32'h202, 32'd0, 32'h12348056, 1, 2, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 2, 1'b0, 32'h102, 32'd0, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 1, 1'b0, 32'h102, 32'h0000BEEF, 32'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 1, 1'b1, 32'h201, 32'd0, 32'h12345678, 0, 0, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 3, 1'b0, 32'h200, 32'h11223344, 32'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 2, 1'b0, 32'h180, 32'h55AA55AA, 32'd0, 0, 0, 1'b1, 1'b0, 1'b0);
        do_op(1'b0, 2, 1'b0, 32'h204, 32'd0, 32'h87654321, 2, 0, 1'b0, 1'b1, 1'b0);
        do_op(1'b1, 0, 1'b0, 32'h311, 32'h0000003C, 32'd0, 2, 0, 1'b0, 1'b0, 1'b1);

        // Reset while waiting for read data: the late rvalid must be ignored
        cfg_g = 0; cfg_r = 6; cfg_no_gnt = 1'b0; cfg_no_rv = 1'b0; cfg_word = 32'hCAFEF00D;
        eb.we = 1'b0; eb.addr = 32'h400; eb.be = 4'b1111; eb.wdata = 32'd0;
        bus_q.push_back(eb);
        @(negedge clk);
        mem_valid = 1'b1; MemRW = 1'b0; MemSize = 2'b10; MemUnsigned = 1'b0; addr = 32'h400;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; mem_valid = 1'b0;
        #1;
        check("waitr_rst_bus_req", 32'(bus_req), 32'd0);
        check("waitr_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("done_after_reset", 32'(n_done), 32'd0);

        // Reset mid-request drops bus_req without waiting for a clock edge
        cfg_no_gnt = 1'b1;
        eb.we = 1'b0; eb.addr = 32'h500; eb.be = 4'b1111; eb.wdata = 32'd0;
        bus_q.push_back(eb);
        @(negedge clk);
        mem_valid = 1'b1; MemRW = 1'b0; MemSize = 2'b10; addr = 32'h500;
        @(negedge clk);
        check("req_before_reset", 32'(bus_req), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0; mem_valid = 1'b0;
        #1;
        check("req_async_drop", 32'(bus_req), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_no_gnt = 1'b0;
        repeat (2) @(negedge clk);

        do_op(1'b0, 2, 1'b0, 32'h300, 32'd0, 32'h0BADF00D, 1, 1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            int sz;
            sz = ($urandom % 8 == 0) ? 3 : int'($urandom % 3);
            do_op(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom,
                  int'($urandom % 4), int'($urandom % 3), 1'b0, 1'b0, ($urandom % 6 == 0));
        end

        repeat (4) @(negedge clk);
        check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
